// File: rtl/spi_frame_receiver.sv
// Oversampled SPI byte receiver with a 0x55/0xAA header deframer.
// Five 32-bit measurement words update atomically once per complete 20-byte frame.
module spi_frame_receiver #(
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int ERR_CNT_W      = 16
) (
   input  logic                 sys_clk,
   input  logic                 rst,
   input  logic                 sck,
   input  logic                 miso,
   input  logic                 cs,
   output logic [7:0]           byte_data,
   output logic                 byte_valid,
   output logic [31:0]          freq0,
   output logic [31:0]          freq1,
   output logic [31:0]          phase_diff,
   output logic [31:0]          high_cnt,
   output logic [31:0]          low_cnt,
   output logic                 frame_valid,
   output logic                 frame_err,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {HUNT0, HUNT1, PAYLOAD} state_t;

   state_t         state;
   logic [2:0]     sck_p;
   logic [2:0]     cs_p;
   logic [1:0]     miso_p;
   logic [7:0]     sr;
   logic [3:0]     bit_cnt;
   logic [4:0]     idx;
   logic [151:0]   stage;
   logic [TW-1:0]  tmo_cnt;

   logic           sck_rise;
   logic           cs_rise;
   logic           cs_fall;
   logic           byte_bad;
   logic           tmo_hit;
   logic           err_now;
   logic [159:0]   full_frame;

   // Index [1] is the synchronized value, [2] the history flop used for edge detection.
   always_comb begin
      sck_rise   = sck_p[1] & ~sck_p[2];
      cs_rise    = cs_p[1] & ~cs_p[2];
      cs_fall    = ~cs_p[1] & cs_p[2];
      byte_bad   = cs_rise && (bit_cnt != 4'd8);
      tmo_hit    = (state != HUNT0) && !byte_valid && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
      err_now    = byte_bad | tmo_hit;
      full_frame = {stage, byte_data};
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         sck_p       <= 3'b000;
         cs_p        <= 3'b111;
         miso_p      <= 2'b00;
         sr          <= '0;
         bit_cnt     <= '0;
         idx         <= '0;
         stage       <= '0;
         tmo_cnt     <= '0;
         state       <= HUNT0;
         byte_data   <= '0;
         byte_valid  <= 1'b0;
         freq0       <= '0;
         freq1       <= '0;
         phase_diff  <= '0;
         high_cnt    <= '0;
         low_cnt     <= '0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         err_cnt     <= '0;
      end else begin
         sck_p       <= {sck_p[1:0], sck};
         cs_p        <= {cs_p[1:0], cs};
         miso_p      <= {miso_p[0], miso};
         byte_valid  <= 1'b0;
         frame_valid <= 1'b0;
         frame_err   <= err_now;
         if (err_now && (err_cnt != {ERR_CNT_W{1'b1}}))
            err_cnt <= err_cnt + 1'b1;

         // cs_rise implies synced cs is high, so a coincident sck edge is dropped here.
         if (cs_fall) begin
            bit_cnt <= '0;
         end else if (cs_rise) begin
            bit_cnt <= '0;
            if (bit_cnt == 4'd8) begin
               byte_data  <= sr;
               byte_valid <= 1'b1;
            end
         end else if (sck_rise && !cs_p[1]) begin
            sr <= {sr[6:0], miso_p[1]};
            if (bit_cnt != 4'd9)
               bit_cnt <= bit_cnt + 1'b1;
         end

         if (err_now) begin
            state   <= HUNT0;
            tmo_cnt <= '0;
         end else if (byte_valid) begin
            tmo_cnt <= '0;
            case (state)
               HUNT0: if (byte_data == 8'h55) state <= HUNT1;
               HUNT1: begin
                  if (byte_data == 8'hAA) begin
                     state <= PAYLOAD;
                     idx   <= '0;
                  end else if (byte_data != 8'h55) begin
                     state <= HUNT0;
                  end
               end
               PAYLOAD: begin
                  stage <= {stage[143:0], byte_data};
                  idx   <= idx + 1'b1;
                  if (idx == 5'd19) begin
                     freq0       <= full_frame[159:128];
                     freq1       <= full_frame[127:96];
                     phase_diff  <= full_frame[95:64];
                     high_cnt    <= full_frame[63:32];
                     low_cnt     <= full_frame[31:0];
                     frame_valid <= 1'b1;
                     state       <= HUNT0;
                  end
               end
               default: state <= HUNT0;
            endcase
         end else if (state != HUNT0) begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end else begin
            tmo_cnt <= '0;
         end
      end
   end

endmodule
